wb_commit: RTL and testbench

- Writeback/commit stage that sits on the write side of the integer register file.
- Accepts retiring instructions from MEM through a valid/ready handshake and buffers them in a small FIFO.
- Drains at most one entry per cycle and, on the same edge, registers the regfile write port (WriteAddr/WriteData/WriteEnable).
- Also produces difftest commit info, cycle/instret counters, and halt-on-good-trap.

---
 rtl/wb_commit_pkg.sv | 36 +++
 rtl/wb_commit_fifo.sv | 55 +++++
 rtl/wb_commit.sv | 165 ++++++++++++++++
 tb/tb_wb_commit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_commit_pkg.sv
// Shared types and entry-packing helpers for the writeback/commit stage.
// Entry layout (MSB..LSB): pc | inst | wen | addr | data.
package wb_commit_pkg;

    localparam int unsigned INST_W        = 32;
    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned CNT64_W       = 64;
    localparam int unsigned TRAP_CODE_W   = 8;
    localparam logic [31:0] TRAP_INST_DEF = 32'h0000006b;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    function automatic int unsigned entry_w(input int unsigned xlen);
        return 2 * xlen + INST_W + 1 + ADDR_W;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned xlen);
        return xlen;
    endfunction

    function automatic int unsigned wen_bit(input int unsigned xlen);
        return xlen + ADDR_W;
    endfunction

    function automatic int unsigned inst_lsb(input int unsigned xlen);
        return xlen + ADDR_W + 1;
    endfunction

    function automatic int unsigned pc_lsb(input int unsigned xlen);
        return xlen + ADDR_W + 1 + INST_W;
    endfunction

endpackage

// File: rtl/wb_commit_fifo.sv
// DEPTH-entry ring buffer (power-of-two depth) holding packed retiring instructions.
module wb_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Storage needs no reset: an empty count makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: buffers retiring instructions, drives the regfile write port,
// counters and halt-on-trap. Difftest commit outputs exist only when WB_DIFFTEST_EN is defined.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] TRAP_INST = TRAP_INST_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    input  logic [XLEN-1:0]        mem_pc_i,
    input  logic [INST_W-1:0]      mem_inst_i,
    input  logic                   mem_rd_wen_i,
    input  logic [ADDR_W-1:0]      mem_rd_addr_i,
    input  logic [XLEN-1:0]        mem_rd_data_i,
    input  logic                   commit_stall_i,
    input  logic [XLEN-1:0]        a0_i,
    output logic [ADDR_W-1:0]      WriteAddr,
    output logic [XLEN-1:0]        WriteData,
    output logic                   WriteEnable,
    output logic                   commit_valid_o,
    output logic [XLEN-1:0]        commit_pc_o,
    output logic [INST_W-1:0]      commit_inst_o,
    output logic                   commit_wen_o,
    output logic [CNT64_W-1:0]     cycle_cnt_o,
    output logic [CNT64_W-1:0]     instret_o,
    output logic                   trap_valid_o,
    output logic [TRAP_CODE_W-1:0] trap_code_o
);

    localparam int unsigned ENTRY_W  = entry_w(XLEN);
    localparam int unsigned ADDR_LSB = addr_lsb(XLEN);
    localparam int unsigned WEN_BIT  = wen_bit(XLEN);
    localparam int unsigned INST_LSB = inst_lsb(XLEN);
    localparam int unsigned PC_LSB   = pc_lsb(XLEN);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ENTRY_W-1:0]   w_push_entry;
    logic [ENTRY_W-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_drain;
    logic                 w_run;
    logic                 w_head_wen;
    logic [ADDR_W-1:0]    w_head_addr;
    logic [XLEN-1:0]      w_head_data;
    logic [INST_W-1:0]    w_head_inst;
    logic                 w_write_en;
    logic                 w_trap_hit;
    logic [XLEN-1:0]      w_unused_a0;

    assign w_run        = (r_state == ST_RUN);
    assign mem_ready_o  = !rst && !w_full && w_run;
    assign w_push       = mem_valid_i && mem_ready_o;
    assign w_drain      = !w_empty && !commit_stall_i && w_run;
    assign w_push_entry = {mem_pc_i, mem_inst_i, mem_rd_wen_i, mem_rd_addr_i, mem_rd_data_i};

    assign w_head_data = w_head[XLEN-1:0];
    assign w_head_addr = w_head[ADDR_LSB +: ADDR_W];
    assign w_head_wen  = w_head[WEN_BIT];
    assign w_head_inst = w_head[INST_LSB +: INST_W];
    assign w_write_en  = w_head_wen && (w_head_addr != '0);
    assign w_trap_hit  = w_drain && (w_head_inst == TRAP_INST);
    assign w_unused_a0 = a0_i;

    wb_fifo #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_drain),
        .i_wdata (w_push_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // HALT is terminal until reset.
    always_comb begin
        w_state_nxt = r_state;
        if (w_trap_hit) begin
            w_state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WriteAddr    <= '0;
            WriteData    <= '0;
            WriteEnable  <= 1'b0;
            cycle_cnt_o  <= '0;
            instret_o    <= '0;
            trap_valid_o <= 1'b0;
            trap_code_o  <= '0;
        end else begin
            WriteEnable <= 1'b0;
            if (w_run) begin
                cycle_cnt_o <= cycle_cnt_o + CNT64_W'(1);
            end
            if (w_drain) begin
                WriteEnable <= w_write_en;
                WriteAddr   <= w_head_addr;
                WriteData   <= w_head_data;
                instret_o   <= instret_o + CNT64_W'(1);
            end
            // a0_i already carries the previous drain's write via regfile forwarding.
            if (w_trap_hit) begin
                trap_valid_o <= 1'b1;
                trap_code_o  <= a0_i[TRAP_CODE_W-1:0];
            end
        end
    end

`ifdef WB_DIFFTEST_EN
    logic              r_commit_valid;
    logic [XLEN-1:0]   r_commit_pc;
    logic [INST_W-1:0] r_commit_inst;
    logic              r_commit_wen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_valid <= 1'b0;
            r_commit_pc    <= '0;
            r_commit_inst  <= '0;
            r_commit_wen   <= 1'b0;
        end else begin
            r_commit_valid <= w_drain;
            if (w_drain) begin
                r_commit_pc   <= w_head[PC_LSB +: XLEN];
                r_commit_inst <= w_head_inst;
                r_commit_wen  <= w_write_en;
            end
        end
    end

    assign commit_valid_o = r_commit_valid;
    assign commit_pc_o    = r_commit_pc;
    assign commit_inst_o  = r_commit_inst;
    assign commit_wen_o   = r_commit_wen;
`else
    logic [XLEN-1:0] w_unused_pc;

    assign w_unused_pc    = w_head[PC_LSB +: XLEN];
    assign commit_valid_o = 1'b0;
    assign commit_pc_o    = '0;
    assign commit_inst_o  = '0;
    assign commit_wen_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed scenarios then randomized traffic,
// all checked against a queue-based reference model.
module tb_wb_commit;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] TRAP  = 32'h0000006b;
`ifdef WB_DIFFTEST_EN
    localparam bit DT = 1'b1;
`else
    localparam bit DT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_valid_i = 1'b0;
    logic            mem_ready_o;
    logic [XLEN-1:0] mem_pc_i = '0;
    logic [31:0]     mem_inst_i = '0;
    logic            mem_rd_wen_i = 1'b0;
    logic [4:0]      mem_rd_addr_i = '0;
    logic [XLEN-1:0] mem_rd_data_i = '0;
    logic            commit_stall_i = 1'b0;
    logic [XLEN-1:0] a0_i = '0;
    logic [4:0]      WriteAddr;
    logic [XLEN-1:0] WriteData;
    logic            WriteEnable;
    logic            commit_valid_o;
    logic [XLEN-1:0] commit_pc_o;
    logic [31:0]     commit_inst_o;
    logic            commit_wen_o;
    logic [63:0]     cycle_cnt_o;
    logic [63:0]     instret_o;
    logic            trap_valid_o;
    logic [7:0]      trap_code_o;

    wb_commit #(.XLEN(XLEN), .DEPTH(DEPTH), .TRAP_INST(TRAP)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .mem_pc_i(mem_pc_i), .mem_inst_i(mem_inst_i),
        .mem_rd_wen_i(mem_rd_wen_i), .mem_rd_addr_i(mem_rd_addr_i),
        .mem_rd_data_i(mem_rd_data_i), .commit_stall_i(commit_stall_i),
        .a0_i(a0_i),
        .WriteAddr(WriteAddr), .WriteData(WriteData), .WriteEnable(WriteEnable),
        .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o),
        .commit_inst_o(commit_inst_o), .commit_wen_o(commit_wen_o),
        .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o),
        .trap_valid_o(trap_valid_o), .trap_code_o(trap_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  addr;
        logic [63:0] data;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    bit          m_halt;
    logic        m_we, m_cv, m_cwen, m_trap;
    logic [4:0]  m_waddr;
    logic [63:0] m_wdata, m_cpc, m_cyc, m_instret;
    logic [31:0] m_cinst;
    logic [7:0]  m_tcode;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_halt = 0; m_we = 0; m_cv = 0; m_cwen = 0; m_trap = 0;
        m_waddr = '0; m_wdata = '0; m_cpc = '0; m_cyc = '0; m_instret = '0;
        m_cinst = '0; m_tcode = '0;
    endtask

    task automatic check_all(input bit in_rst);
        bit exp_ready;
        exp_ready = !in_rst && !m_halt && (q.size() < DEPTH);
        chk("ready",     64'(mem_ready_o),    64'(exp_ready));
        chk("wen",       64'(WriteEnable),    64'(m_we));
        chk("waddr",     64'(WriteAddr),      64'(m_waddr));
        chk("wdata",     WriteData,           m_wdata);
        chk("cvalid",    64'(commit_valid_o), DT ? 64'(m_cv) : 64'd0);
        chk("cpc",       commit_pc_o,         DT ? m_cpc : 64'd0);
        chk("cinst",     64'(commit_inst_o),  DT ? 64'(m_cinst) : 64'd0);
        chk("cwen",      64'(commit_wen_o),   DT ? 64'(m_cwen) : 64'd0);
        chk("cycle",     cycle_cnt_o,         m_cyc);
        chk("instret",   instret_o,           m_instret);
        chk("trapvalid", 64'(trap_valid_o),   64'(m_trap));
        chk("trapcode",  64'(trap_code_o),    64'(m_tcode));
    endtask

    // Predict one clock edge from current inputs, advance, then compare.
    task automatic step();
        bit   drain, push;
        ent_t e, n;
        drain = !m_halt && (q.size() != 0) && !commit_stall_i;
        push  = mem_valid_i && !m_halt && (q.size() < DEPTH);
        n.pc = mem_pc_i; n.inst = mem_inst_i; n.wen = mem_rd_wen_i;
        n.addr = mem_rd_addr_i; n.data = mem_rd_data_i;
        if (!m_halt) m_cyc = m_cyc + 64'd1;
        if (drain) begin
            e         = q.pop_front();
            m_we      = e.wen && (e.addr != 5'd0);
            m_waddr   = e.addr;
            m_wdata   = e.data;
            m_cv      = 1'b1;
            m_cpc     = e.pc;
            m_cinst   = e.inst;
            m_cwen    = m_we;
            m_instret = m_instret + 64'd1;
            if (e.inst == TRAP) begin
                m_halt  = 1;
                m_trap  = 1'b1;
                m_tcode = a0_i[7:0];
            end
        end else begin
            m_we = 1'b0;
            m_cv = 1'b0;
        end
        if (push) q.push_back(n);
        @(posedge clk);
        #1;
        check_all(1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        #1;
        check_all(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_all(1'b1);
        rst = 1'b0;
        #1;
        check_all(1'b0);
    endtask

    task automatic set_in(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                          input bit wen, input logic [4:0] addr, input logic [63:0] data);
        mem_valid_i = v; mem_pc_i = pc; mem_inst_i = inst;
        mem_rd_wen_i = wen; mem_rd_addr_i = addr; mem_rd_data_i = data;
    endtask

    logic [63:0] cyc_at_halt;
    logic [31:0] rinst;

    initial begin
        model_clear();
        do_reset();

        // Single push: regfile write visible one cycle after acceptance
        set_in(1, 64'h8000_0000, 32'h0012_3293, 1, 5'd5, 64'h1234);
        step();
        chk("single_wen_early", 64'(WriteEnable), 64'd0);
        set_in(0, '0, '0, 0, '0, '0);
        step();
        chk("single_wen",     64'(WriteEnable), 64'd1);
        chk("single_addr",    64'(WriteAddr), 64'd5);
        chk("single_data",    WriteData, 64'h1234);
        chk("single_instret", instret_o, 64'd1);
        chk("single_cvalid",  64'(commit_valid_o), DT ? 64'd1 : 64'd0);
        chk("single_cpc",     commit_pc_o, DT ? 64'h8000_0000 : 64'd0);
        step();
        chk("single_pulse",   64'(commit_valid_o), 64'd0);

        // Write to x0 commits but never writes
        set_in(1, 64'h8000_0004, 32'h0000_0013, 1, 5'd0, 64'hdead);
        step();
        set_in(0, '0, '0, 0, '0, '0);
        step();
        chk("x0_wen",     64'(WriteEnable), 64'd0);
        chk("x0_cwen",    64'(commit_wen_o), 64'd0);
        chk("x0_cvalid",  64'(commit_valid_o), DT ? 64'd1 : 64'd0);
        chk("x0_instret", instret_o, 64'd2);

        // Stall with continuous valid: fills after two accepts, then drains in order
        commit_stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 64'h8000_0100 + 64'(4 * i), 32'h0000_0033 + 32'(i << 7), 1,
                   5'(i + 1), 64'h100 + 64'(i));
            step();
        end
        chk("stall_full_ready", 64'(mem_ready_o), 64'd0);
        commit_stall_i = 1'b0;
        for (int i = 3; i < 7; i++) begin
            set_in(1, 64'h8000_0100 + 64'(4 * i), 32'h0000_0033 + 32'(i << 7), 1,
                   5'(i + 1), 64'h100 + 64'(i));
            step();
        end
        set_in(0, '0, '0, 0, '0, '0);
        repeat (3) step();

        // Asynchronous reset with two entries queued mid-stall
        commit_stall_i = 1'b1;
        set_in(1, 64'h8000_0200, 32'h0000_00b3, 1, 5'd9, 64'h55);
        repeat (2) step();
        #2;
        do_reset();
        commit_stall_i = 1'b0;
        set_in(0, '0, '0, 0, '0, '0);
        repeat (3) step();
        chk("rst_no_write", 64'(WriteEnable), 64'd0);
        chk("rst_instret",  instret_o, 64'd0);
        chk("rst_cycle",    cycle_cnt_o, 64'd3);

        // Trap with a0=0, followed by an entry that must never write
        a0_i = '0;
        set_in(1, 64'h8000_0300, TRAP, 0, 5'd0, 64'd0);
        step();
        set_in(1, 64'h8000_0304, 32'h0000_0393, 1, 5'd7, 64'h77);
        step();
        cyc_at_halt = m_cyc;
        chk("trap_valid", 64'(trap_valid_o), 64'd1);
        chk("trap_code",  64'(trap_code_o), 64'd0);
        chk("trap_ready", 64'(mem_ready_o), 64'd0);
        for (int i = 0; i < 4; i++) begin
            commit_stall_i = 1'(i & 1);
            step();
            chk("halt_no_write", 64'(WriteEnable), 64'd0);
        end
        chk("halt_cycle_frozen", cycle_cnt_o, cyc_at_halt);
        chk("halt_instret", instret_o, 64'd1);

        // Randomized traffic with occasional traps and resets
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rinst = $urandom();
            if (rinst == TRAP) rinst = rinst ^ 32'h100;
            if ($urandom_range(0, 59) == 0) rinst = TRAP;
            set_in(1'($urandom_range(0, 3) != 0), {$urandom(), $urandom()}, rinst,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   {$urandom(), $urandom()});
            commit_stall_i = ($urandom_range(0, 3) == 0);
            a0_i = {$urandom(), $urandom()};
            step();
            if (m_halt && $urandom_range(0, 7) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
